// File: rtl/des_key_sched_ctrl_pkg.sv
// DES key-schedule tables, the per-round shift schedule, rotation helpers and the controller state type.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_e;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // DES bit n of the key sits at vector index 64-n, so PC-1 output bit 1 lands on cd[55].
  function automatic logic [55:0] pc1Permute(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[6'(64 - PC1_TBL[i])];
    return cd;
  endfunction

  // Decrypt walks the encrypt schedule backwards, starting from the unrotated C0/D0.
  function automatic logic [1:0] shiftAmount(input logic enc, input logic [3:0] idx);
    logic [1:0] amt;
    if (enc)              amt = 2'(SHIFT_TBL[idx]);
    else if (idx == 4'd0) amt = 2'd0;
    else                  amt = 2'(SHIFT_TBL[4'd0 - idx]);
    return amt;
  endfunction

  function automatic logic [27:0] rotate28(input logic [27:0] x, input logic left,
                                           input logic [1:0] amt);
    logic [27:0] r;
    case ({left, amt})
      3'b101:  r = {x[26:0], x[27]};
      3'b110:  r = {x[25:0], x[27:26]};
      3'b001:  r = {x[0], x[27:1]};
      3'b010:  r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [55:0] rotateCd(input logic [55:0] cd, input logic left,
                                           input logic [1:0] amt);
    return {rotate28(cd[55:28], left, amt), rotate28(cd[27:0], left, amt)};
  endfunction

  function automatic logic keyParityOk(input logic [63:0] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^key[8*b +: 8]);
    return ok;
  endfunction

endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// Key-load and round-key handshake bundle between the controller (slave) and its user (master).
interface des_key_sched_ctrl_if;

  logic        key_valid;
  logic        key_ready;
  logic [63:0] init_key;
  logic        encrypt_decrypt;
  logic        abort;
  logic [47:0] round_key;
  logic        round_key_valid;
  logic        round_key_ready;
  logic [3:0]  round_idx;
  logic        done;
  logic        parity_err;

  modport master (
    output key_valid, init_key, encrypt_decrypt, abort, round_key_ready,
    input  key_ready, round_key, round_key_valid, round_idx, done, parity_err
  );

  modport slave (
    input  key_valid, init_key, encrypt_decrypt, abort, round_key_ready,
    output key_ready, round_key, round_key_valid, round_idx, done, parity_err
  );

endinterface

// File: rtl/des_key_sched_ctrl_pc2.sv
// Combinational PC-2: selects the 48 round-key bits from the 56-bit C/D pair.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] key_o
);

  always_comb begin
    key_o = '0;
    for (int i = 0; i < 48; i++) key_o[47 - i] = cd_i[6'(56 - PC2_TBL[i])];
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule controller: rotates C/D one round per handshake and presents PC-2 round keys.
// Define DES_KEY_PARITY_CHK_EN to reject keys whose bytes are not odd parity.
module des_key_sched_ctrl
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  des_key_sched_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic        encMode_q, encMode_d;
  logic [3:0]  roundIdx_q, roundIdx_d;
  logic [47:0] pc2Key;
  logic        keyBad;

  des_pc2 u_pc2 (.cd_i(cd_q), .key_o(pc2Key));

`ifdef DES_KEY_PARITY_CHK_EN
  logic parityErr_q, parityErr_d;

  // A bad key is still consumed; only the error pulse records it.
  assign keyBad      = !keyParityOk(bus.init_key);
  assign parityErr_d = (state_q == IDLE) && bus.key_valid && keyBad;

  always_ff @(posedge clk) begin
    if (rst) parityErr_q <= 1'b0;
    else     parityErr_q <= parityErr_d;
  end

  assign bus.parity_err = parityErr_q;
`else
  assign keyBad         = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cd_q       <= '0;
      encMode_q  <= 1'b0;
      roundIdx_q <= '0;
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      encMode_q  <= encMode_d;
      roundIdx_q <= roundIdx_d;
    end
  end

  // C/D always hold the already-rotated pair for the key being presented; abort outranks a handshake.
  always_comb begin
    state_d    = state_q;
    cd_d       = cd_q;
    encMode_d  = encMode_q;
    roundIdx_d = roundIdx_q;
    case (state_q)
      IDLE: begin
        if (bus.key_valid && !keyBad) begin
          state_d    = ISSUE;
          encMode_d  = bus.encrypt_decrypt;
          roundIdx_d = 4'd0;
          cd_d       = rotateCd(pc1Permute(bus.init_key), bus.encrypt_decrypt,
                                shiftAmount(bus.encrypt_decrypt, 4'd0));
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.round_key_ready) begin
          if (roundIdx_q == 4'd15) begin
            state_d = FIN;
          end else begin
            roundIdx_d = roundIdx_q + 4'd1;
            cd_d       = rotateCd(cd_q, encMode_q, shiftAmount(encMode_q, roundIdx_q + 4'd1));
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.key_ready       = (state_q == IDLE);
  assign bus.round_key_valid = (state_q == ISSUE);
  assign bus.round_key       = (state_q == ISSUE) ? pc2Key : '0;
  assign bus.round_idx       = (state_q == ISSUE) ? roundIdx_q : '0;
  assign bus.done            = (state_q == FIN) && !bus.abort;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl using the classic 0x133457799BBCDFF1 key schedule.
module tb_des_key_sched_ctrl;

  typedef struct {
    logic [3:0]  round;
    logic [47:0] encKey;
    logic [47:0] decKey;
  } vec_t;

  localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
  localparam logic [63:0] BAD_KEY = 64'h133457799BBCDFF0;

  localparam logic [47:0] ENC_KEYS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  vec_t vecTbl [16];

  des_key_sched_ctrl_if busIf ();

  des_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read 1 time unit later.
  task automatic applyStimulus(input logic rstIn, input logic keyValid, input logic [63:0] key,
                               input logic enc, input logic abortIn, input logic rkReady);
    @(negedge clk);
    rst                   = rstIn;
    busIf.key_valid       = keyValid;
    busIf.init_key        = key;
    busIf.encrypt_decrypt = enc;
    busIf.abort           = abortIn;
    busIf.round_key_ready = rkReady;
    #1;
  endtask

  function automatic logic [47:0] expKey(input logic enc, input int idx);
    if (idx < 0 || idx > 15) return '0;
    return enc ? vecTbl[idx].encKey : vecTbl[idx].decKey;
  endfunction

  // Full schedule; while keys are expected, key_valid is driven with a bogus key that must be ignored.
  task automatic runSchedule(input string tag, input logic enc, input logic [63:0] key, input bit randStall);
    int   hs;
    int   donePulses;
    int   doneCyc;
    logic rdy;
    hs = 0;
    donePulses = 0;
    doneCyc = 0;
    applyStimulus(1'b0, 1'b1, key, enc, 1'b0, 1'b0);
    checkOutput({tag, " key_ready idle"}, 64'(busIf.key_ready), 64'd1);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      rdy = randStall ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(1'b0, (hs < 16), ~key, ~enc, 1'b0, rdy);
      if (cyc == 1) checkOutput({tag, " parity_err"}, 64'(busIf.parity_err), 64'd0);
      if (doneCyc != 0 && cyc == doneCyc + 1) begin
        checkOutput({tag, " done cleared"}, 64'(busIf.done), 64'd0);
        checkOutput({tag, " back to idle"}, 64'(busIf.key_ready), 64'd1);
        break;
      end
      if (busIf.round_key_valid) begin
        checkOutput({tag, " key_ready busy"}, 64'(busIf.key_ready), 64'd0);
        checkOutput({tag, " round_idx"}, 64'(busIf.round_idx), (hs < 16) ? 64'(vecTbl[hs].round) : 64'(hs));
        checkOutput({tag, " round_key"}, 64'(busIf.round_key), 64'(expKey(enc, hs)));
        if (rdy) hs++;
      end
      if (busIf.done) begin
        donePulses++;
        doneCyc = cyc;
        checkOutput({tag, " key_ready in FIN"}, 64'(busIf.key_ready), 64'd0);
      end
    end
    checkOutput({tag, " handshakes"}, 64'(hs), 64'd16);
    checkOutput({tag, " done pulses"}, 64'(donePulses), 64'd1);
    if (!randStall) checkOutput({tag, " done latency"}, 64'(doneCyc), 64'd17);
  endtask

  task automatic startAndAdvance(input logic enc, input int n);
    applyStimulus(1'b0, 1'b1, KEY, enc, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, KEY, enc, 1'b0, 1'b1);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    for (int i = 0; i < 16; i++) begin
      vecTbl[i].round  = 4'(i);
      vecTbl[i].encKey = ENC_KEYS[i];
      vecTbl[i].decKey = ENC_KEYS[15 - i];
    end
    rst                   = 1'b1;
    busIf.key_valid       = 1'b0;
    busIf.init_key        = '0;
    busIf.encrypt_decrypt = 1'b0;
    busIf.abort           = 1'b0;
    busIf.round_key_ready = 1'b0;

    $display("[TB] reset values");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset key_ready", 64'(busIf.key_ready), 64'd1);
    checkOutput("reset round_key_valid", 64'(busIf.round_key_valid), 64'd0);
    checkOutput("reset round_key", 64'(busIf.round_key), 64'd0);
    checkOutput("reset round_idx", 64'(busIf.round_idx), 64'd0);
    checkOutput("reset done", 64'(busIf.done), 64'd0);
    checkOutput("reset parity_err", 64'(busIf.parity_err), 64'd0);

    $display("[TB] encrypt, decrypt and stalled schedules");
    runSchedule("enc", 1'b1, KEY, 1'b0);
    runSchedule("dec", 1'b0, KEY, 1'b0);
    runSchedule("stall enc", 1'b1, KEY, 1'b1);
    runSchedule("stall dec", 1'b0, KEY, 1'b1);

    $display("[TB] abort at round 7");
    startAndAdvance(1'b1, 7);
    applyStimulus(1'b0, 1'b0, KEY, 1'b1, 1'b1, 1'b1);
    checkOutput("abort at idx", 64'(busIf.round_idx), 64'd7);
    checkOutput("abort key", 64'(busIf.round_key), 64'(vecTbl[7].encKey));
    applyStimulus(1'b0, 1'b0, KEY, 1'b1, 1'b0, 1'b1);
    checkOutput("abort key_ready", 64'(busIf.key_ready), 64'd1);
    checkOutput("abort valid", 64'(busIf.round_key_valid), 64'd0);
    checkOutput("abort round_key", 64'(busIf.round_key), 64'd0);
    checkOutput("abort round_idx", 64'(busIf.round_idx), 64'd0);
    checkOutput("abort done", 64'(busIf.done), 64'd0);
    applyStimulus(1'b0, 1'b0, KEY, 1'b1, 1'b0, 1'b0);
    checkOutput("abort no late done", 64'(busIf.done), 64'd0);

    $display("[TB] abort in IDLE is ignored");
    applyStimulus(1'b0, 1'b1, KEY, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, KEY, 1'b0, 1'b0, 1'b0);
    checkOutput("idle abort accepted", 64'(busIf.round_key_valid), 64'd1);
    checkOutput("idle abort dec key0", 64'(busIf.round_key), 64'(vecTbl[0].decKey));
    applyStimulus(1'b0, 1'b0, KEY, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, KEY, 1'b0, 1'b0, 1'b0);
    checkOutput("abort idx0 key_ready", 64'(busIf.key_ready), 64'd1);

    $display("[TB] reset with abort at round 7");
    startAndAdvance(1'b1, 7);
    applyStimulus(1'b1, 1'b0, KEY, 1'b1, 1'b1, 1'b1);
    checkOutput("rst at idx", 64'(busIf.round_idx), 64'd7);
    applyStimulus(1'b1, 1'b1, KEY, 1'b1, 1'b0, 1'b1);
    checkOutput("rst key_ready", 64'(busIf.key_ready), 64'd1);
    checkOutput("rst valid", 64'(busIf.round_key_valid), 64'd0);
    checkOutput("rst round_idx", 64'(busIf.round_idx), 64'd0);
    checkOutput("rst done", 64'(busIf.done), 64'd0);
    applyStimulus(1'b0, 1'b0, KEY, 1'b1, 1'b0, 1'b0);
    checkOutput("rst blocks key_valid", 64'(busIf.round_key_valid), 64'd0);
    checkOutput("rst no late done", 64'(busIf.done), 64'd0);
    runSchedule("post rst", 1'b1, KEY, 1'b0);

    $display("[TB] abort in FIN");
    startAndAdvance(1'b1, 16);
    applyStimulus(1'b0, 1'b0, KEY, 1'b1, 1'b1, 1'b0);
    checkOutput("fin abort done", 64'(busIf.done), 64'd0);
    checkOutput("fin key_ready", 64'(busIf.key_ready), 64'd0);
    checkOutput("fin valid", 64'(busIf.round_key_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, KEY, 1'b1, 1'b0, 1'b0);
    checkOutput("fin abort idle", 64'(busIf.key_ready), 64'd1);
    checkOutput("fin abort no done", 64'(busIf.done), 64'd0);

    $display("[TB] key with a bad parity byte");
`ifdef DES_KEY_PARITY_CHK_EN
    applyStimulus(1'b0, 1'b1, BAD_KEY, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, BAD_KEY, 1'b1, 1'b0, 1'b1);
    checkOutput("parity_err pulse", 64'(busIf.parity_err), 64'd1);
    checkOutput("parity no round key", 64'(busIf.round_key_valid), 64'd0);
    checkOutput("parity key_ready", 64'(busIf.key_ready), 64'd1);
    applyStimulus(1'b0, 1'b0, BAD_KEY, 1'b1, 1'b0, 1'b1);
    checkOutput("parity_err single", 64'(busIf.parity_err), 64'd0);
    checkOutput("parity still idle", 64'(busIf.round_key_valid), 64'd0);
    runSchedule("after parity", 1'b1, KEY, 1'b0);
`else
    runSchedule("parity ignored", 1'b1, BAD_KEY, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/des_key_sched_ctrl.md
DES_KEY_SCHED_CTRL -- requirements
Module: des_key_sched_ctrl

Interface
REQ-001 SHALL have no parameters; all widths and tables are fixed by DES.
REQ-002 Ports: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset.
- key_valid  input  1  init_key/encrypt_decrypt offered.
- key_ready  output  1  controller can accept a key.
- init_key  input  64  DES key; bit 63 = DES bit 1.
- encrypt_decrypt  input  1  1 = encrypt order (K1..K16), 0 = decrypt order (K16..K1).
- abort  input  1  drop the current schedule.
- round_key  output  48  current round key; bit 47 = DES bit 1.
- round_key_valid  output  1  round_key is presented.
- round_key_ready  input  1  round datapath consumes round_key.
- round_idx  output  4  issue index 0..15 of the presented key.
- done  output  1  one-cycle pulse after the 16th key is consumed.
- parity_err  output  1  one-cycle pulse on a key parity failure.

Function
REQ-003 SHALL generate round keys iteratively, one per handshake, from 56-bit C/D registers; no 16-stage unrolled schedule.
REQ-004 SHALL use FSM states IDLE, ISSUE and FIN.
REQ-005 IDLE: key_ready=1; key_valid=1 latches PC-1(init_key) into C/D and the mode, then moves to ISSUE with round_idx=0.
REQ-006 Encrypt: each round rotates C and D left by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before PC-2.
REQ-007 Decrypt: each round rotates C and D right by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before PC-2.
REQ-008 round_key SHALL be PC-2 of the registered C/D; C/D hold the rotated value for the current round.
REQ-009 Latency: the key handshake at cycle N gives round_key_valid=1 with round_idx=0 at cycle N+1.
REQ-010 ISSUE: round_key_valid=1; round_key and round_idx SHALL stay stable while round_key_ready=0.
REQ-011 A handshake at round_idx<15 advances C/D and round_idx in the next cycle, with no bubble.
REQ-012 A handshake at round_idx=15 moves to FIN; FIN drives done=1 for one cycle, then returns to IDLE.
REQ-013 key_ready SHALL be 0 in ISSUE and FIN; key_valid there is ignored.
REQ-014 abort=1 in ISSUE or FIN returns to IDLE next cycle with no done pulse.
REQ-015 abort SHALL win over a simultaneous round handshake; abort in IDLE has no effect.
REQ-016 In IDLE, round_key_valid=0 and round_key/round_idx SHALL be 0.

Reset
REQ-017 rst SHALL override all inputs, including abort and handshakes.
REQ-018 rst SHALL force IDLE and clear C/D, mode and round_idx.
REQ-019 Reset values: key_ready=1, round_key_valid=0, round_key=0, round_idx=0, done=0, parity_err=0.
REQ-020 Reset mid-schedule SHALL discard the schedule with no done pulse.

Configuration
REQ-021 With DES_KEY_PARITY_CHK_EN defined, each init_key byte SHALL be checked for odd parity at key accept.
REQ-022 On parity failure the key is consumed, parity_err pulses the next cycle, the FSM stays in IDLE and no round keys are issued.
REQ-023 Without DES_KEY_PARITY_CHK_EN, parity_err SHALL be tied to 0 and parity bits ignored.

Structure
REQ-024 Package des_pkg SHALL hold the PC-1 and PC-2 tables, the 16-entry shift schedule and the FSM state enum.
REQ-025 Sub-module des_pc2 (combinational 56-to-48 PC-2) SHALL be instantiated once; the FSM, rotation and parity logic stay in the top module.

Verification
REQ-026 Encrypt, key 0x133457799BBCDFF1, round_key_ready=1 -> idx0 = 0x1B02EFFC7072, idx15 = 0xCB3D8B0E17F5, done pulses 17 cycles after accept.
REQ-027 Decrypt, same key -> idx0 = 0xCB3D8B0E17F5, idx15 = 0x1B02EFFC7072, all 16 keys reversed against the encrypt run.
REQ-028 Random round_key_ready stalls -> round_key and round_idx stable while stalled, exactly 16 handshakes, then one done pulse.
REQ-029 abort and rst asserted at idx 7 together with round_key_ready=1 -> IDLE next cycle, key_ready=1, no done, a new key is accepted.
REQ-030 With DES_KEY_PARITY_CHK_EN, key 0x133457799BBCDFF0 -> parity_err pulses once, round_key_valid stays 0; without the macro the full schedule runs.
